// File: rtl/n_clic_vec.sv
// Vectored interrupt controller: per-vector config/handler CSRs, priority arbitration,
// and a level stack for nested interrupts.

typedef enum logic [2:0] {
    CsrRw  = 3'd1,
    CsrRs  = 3'd2,
    CsrRc  = 3'd3,
    CsrRwi = 3'd5,
    CsrRsi = 3'd6,
    CsrRci = 3'd7
} csr_op_t;

typedef enum logic {
    PcNormal    = 1'b0,
    PcInterrupt = 1'b1
} pc_interrupt_mux_t;

localparam int unsigned IMemAddrWidth = 32;

module n_clic_vec #(
    parameter int unsigned VecLen     = 8,
    parameter int unsigned PrioLevels = 8,
    parameter logic [11:0] CsrBase    = 12'hB00,
    parameter int unsigned AddrWidth  = IMemAddrWidth,
    localparam int unsigned PrioWidth = $clog2(PrioLevels)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     csr_enable,
    input  logic [11:0]              csr_addr,
    input  csr_op_t                  csr_op,
    input  logic [4:0]               rs1_zimm,
    input  logic [31:0]              rs1_data,
    input  logic [AddrWidth-1:0]     pc_in,
    input  logic [VecLen-1:0]        ext_irq,
    input  logic                     ret_in,
    output logic [31:0]              csr_out,
    output logic [AddrWidth-1:0]     int_addr,
    output pc_interrupt_mux_t        pc_interrupt_sel,
    output logic                     interrupt_out,
    output logic [PrioWidth-1:0]     level_out,
    output logic                     stack_err
);
    localparam int unsigned IdxW = (VecLen > 1) ? $clog2(VecLen) : 1;
    localparam int unsigned StkW = $clog2(PrioLevels);

    logic [VecLen-1:0]    pending_q, pending_d, enable_q;
    logic [PrioWidth-1:0] prio_q [VecLen];
    logic [AddrWidth-1:0] vec_q [VecLen];
    logic [PrioWidth-1:0] cur_level_q;
    logic [PrioWidth-1:0] stack_q [PrioLevels];
    logic [StkW-1:0]      sp_q, sp_top;
    logic                 stack_err_q;

    logic [VecLen-1:0]    cfg_hit, vec_hit;
    logic [31:0]          rdata, operand, wdata;
    logic                 wr_en;
    logic                 found, take;
    logic [IdxW-1:0]      win_idx;
    logic [PrioWidth-1:0] win_prio;

    // The return address is saved outside this block, strobed by interrupt_out.
    logic unused_pc;
    assign unused_pc = ^pc_in;

    always_comb begin
        cfg_hit = '0;
        vec_hit = '0;
        rdata   = '0;
        for (int i = 0; i < VecLen; i++) begin
            cfg_hit[i] = (csr_addr == 12'(CsrBase + i));
            vec_hit[i] = (csr_addr == 12'(CsrBase + VecLen + i));
            if (cfg_hit[i]) rdata |= 32'({prio_q[i], enable_q[i], pending_q[i]});
            if (vec_hit[i]) rdata |= 32'(vec_q[i]);
        end
    end

    always_comb begin
        operand = csr_op[2] ? {27'b0, rs1_zimm} : rs1_data;
        wr_en   = 1'b0;
        wdata   = rdata;
        if (csr_enable) begin
            case (csr_op)
                CsrRw, CsrRwi: begin
                    wr_en = 1'b1;
                    wdata = operand;
                end
                CsrRs, CsrRsi: begin
                    wr_en = |operand;
                    wdata = rdata | operand;
                end
                CsrRc, CsrRci: begin
                    wr_en = |operand;
                    wdata = rdata & ~operand;
                end
                default: ;
            endcase
        end
    end

    // Descending scan with >= leaves the lowest index on a priority tie.
    always_comb begin
        found    = 1'b0;
        win_idx  = '0;
        win_prio = '0;
        for (int i = int'(VecLen) - 1; i >= 0; i--) begin
            if (pending_q[i] && enable_q[i] && (prio_q[i] > cur_level_q) &&
                (!found || prio_q[i] >= win_prio)) begin
                found    = 1'b1;
                win_idx  = IdxW'(i);
                win_prio = prio_q[i];
            end
        end
    end

    assign take = found && !ret_in;

    // Order matters: take-clear, then CSR write, then external set wins over both.
    always_comb begin
        pending_d = pending_q;
        if (take) pending_d[win_idx] = 1'b0;
        for (int i = 0; i < VecLen; i++) begin
            if (wr_en && cfg_hit[i]) pending_d[i] = wdata[0];
        end
        pending_d = pending_d | ext_irq;
    end

    assign sp_top = sp_q - 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_q   <= '0;
            enable_q    <= '0;
            cur_level_q <= '0;
            sp_q        <= '0;
            stack_err_q <= 1'b0;
            for (int i = 0; i < VecLen; i++) begin
                prio_q[i] <= '0;
                vec_q[i]  <= '0;
            end
            for (int i = 0; i < PrioLevels; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            pending_q <= pending_d;
            for (int i = 0; i < VecLen; i++) begin
                if (wr_en && cfg_hit[i]) begin
                    enable_q[i] <= wdata[1];
                    prio_q[i]   <= wdata[PrioWidth+1:2];
                end
                if (wr_en && vec_hit[i]) vec_q[i] <= wdata[AddrWidth-1:0];
            end
            if (take) begin
                stack_q[sp_q] <= cur_level_q;
                sp_q          <= sp_q + 1'b1;
                cur_level_q   <= win_prio;
            end else if (ret_in) begin
                if (sp_q == '0) begin
                    stack_err_q <= 1'b1;
                end else begin
                    cur_level_q <= stack_q[sp_top];
                    sp_q        <= sp_top;
                end
            end
        end
    end

    assign csr_out          = rdata;
    assign interrupt_out    = take;
    assign pc_interrupt_sel = take ? PcInterrupt : PcNormal;
    assign int_addr         = take ? vec_q[win_idx] : '0;
    assign level_out        = take ? win_prio : cur_level_q;
    assign stack_err        = stack_err_q;

endmodule

// File: tb/tb_n_clic_vec.sv
// Directed self-checking bench for n_clic_vec: CSR access, arbitration, nesting,
// return handling and reset behaviour.

module tb_n_clic_vec;
    localparam logic [11:0] Cfg0 = 12'hB00, Cfg1 = 12'hB01, Cfg2 = 12'hB02, Cfg4 = 12'hB04;
    localparam logic [11:0] Cfg5 = 12'hB05, Cfg6 = 12'hB06;
    localparam logic [11:0] Vec0 = 12'hB08, Vec1 = 12'hB09, Vec2 = 12'hB0A, Vec4 = 12'hB0C;
    localparam logic [11:0] Vec5 = 12'hB0D, Vec6 = 12'hB0E;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              csr_enable = 1'b0;
    logic [11:0]       csr_addr = '0;
    csr_op_t           csr_op = CsrRw;
    logic [4:0]        rs1_zimm = '0;
    logic [31:0]       rs1_data = '0;
    logic [31:0]       pc_in = 32'h100;
    logic [7:0]        ext_irq = '0;
    logic              ret_in = 1'b0;
    logic [31:0]       csr_out;
    logic [31:0]       int_addr;
    pc_interrupt_mux_t pc_interrupt_sel;
    logic              interrupt_out;
    logic [2:0]        level_out;
    logic              stack_err;

    int total = 0;
    int bad = 0;
    logic [31:0] v;

    n_clic_vec dut (
        .clk              (clk),
        .reset            (reset),
        .csr_enable       (csr_enable),
        .csr_addr         (csr_addr),
        .csr_op           (csr_op),
        .rs1_zimm         (rs1_zimm),
        .rs1_data         (rs1_data),
        .pc_in            (pc_in),
        .ext_irq          (ext_irq),
        .ret_in           (ret_in),
        .csr_out          (csr_out),
        .int_addr         (int_addr),
        .pc_interrupt_sel (pc_interrupt_sel),
        .interrupt_out    (interrupt_out),
        .level_out        (level_out),
        .stack_err        (stack_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    // Advance one rising edge; return just after it.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_wr(input logic [11:0] a, input csr_op_t op, input logic [31:0] d,
                          input logic [4:0] z);
        csr_enable = 1'b1; csr_addr = a; csr_op = op; rs1_data = d; rs1_zimm = z;
        cycle();
        csr_enable = 1'b0; rs1_data = '0; rs1_zimm = '0;
    endtask

    task automatic rd(input logic [11:0] a, output logic [31:0] r);
        csr_addr = a;
        #1 r = csr_out;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        cycle(); cycle();
        total++; if (interrupt_out !== 1'b0) begin bad++; $display("FAIL rst_io got=%0b exp=0", interrupt_out); end
        total++; if (level_out !== 3'd0) begin bad++; $display("FAIL rst_level got=%0d exp=0", level_out); end
        total++; if (stack_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%0b exp=0", stack_err); end
        total++; if (pc_interrupt_sel !== PcNormal) begin bad++; $display("FAIL rst_sel got=%0b exp=0", pc_interrupt_sel); end
        rd(Cfg0, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL rst_cfg0 got=%h exp=0", v); end
        reset = 1'b1;
        #1;
    endtask

    task automatic test_basic();
        csr_wr(Vec1, CsrRw, 32'h40, 5'd0);
        csr_wr(Cfg1, CsrRw, 32'hF, 5'd0);
        #1;
        total++; if (interrupt_out !== 1'b1) begin bad++; $display("FAIL basic_io got=%0b exp=1", interrupt_out); end
        total++; if (pc_interrupt_sel !== PcInterrupt) begin bad++; $display("FAIL basic_sel got=%0b exp=1", pc_interrupt_sel); end
        total++; if (int_addr !== 32'h40) begin bad++; $display("FAIL basic_addr got=%h exp=40", int_addr); end
        total++; if (level_out !== 3'd3) begin bad++; $display("FAIL basic_level got=%0d exp=3", level_out); end
        rd(Cfg1, v);
        total++; if (v !== 32'hF) begin bad++; $display("FAIL basic_cfg1 got=%h exp=f", v); end
        rd(Vec1, v);
        total++; if (v !== 32'h40) begin bad++; $display("FAIL basic_vec1 got=%h exp=40", v); end
        cycle();
        total++; if (interrupt_out !== 1'b0) begin bad++; $display("FAIL basic_io2 got=%0b exp=0", interrupt_out); end
        total++; if (level_out !== 3'd3) begin bad++; $display("FAIL basic_level2 got=%0d exp=3", level_out); end
        rd(Cfg1, v);
        total++; if (v !== 32'hE) begin bad++; $display("FAIL basic_pend_clr got=%h exp=e", v); end
        csr_wr(12'hB10, CsrRw, 32'hFFFF_FFFF, 5'd0);
        rd(12'hB10, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL unmapped got=%h exp=0", v); end
        rd(12'hAFF, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL unmapped_lo got=%h exp=0", v); end
    endtask

    task automatic test_nesting();
        csr_wr(Vec2, CsrRw, 32'h60, 5'd0);
        csr_wr(Cfg2, CsrRw, 32'hB, 5'd0);
        #1;
        total++; if (interrupt_out !== 1'b0) begin bad++; $display("FAIL nest_low_io got=%0b exp=0", interrupt_out); end
        total++; if (level_out !== 3'd3) begin bad++; $display("FAIL nest_low_lvl got=%0d exp=3", level_out); end
        csr_wr(Vec4, CsrRw, 32'h80, 5'd0);
        csr_wr(Cfg4, CsrRw, 32'h17, 5'd0);
        #1;
        total++; if (interrupt_out !== 1'b1) begin bad++; $display("FAIL nest_hi_io got=%0b exp=1", interrupt_out); end
        total++; if (int_addr !== 32'h80) begin bad++; $display("FAIL nest_hi_addr got=%h exp=80", int_addr); end
        total++; if (level_out !== 3'd5) begin bad++; $display("FAIL nest_hi_lvl got=%0d exp=5", level_out); end
        cycle();
        total++; if (level_out !== 3'd5) begin bad++; $display("FAIL nest_lvl5 got=%0d exp=5", level_out); end
        ret_in = 1'b1; cycle(); ret_in = 1'b0; #1;
        total++; if (level_out !== 3'd3) begin bad++; $display("FAIL nest_ret1 got=%0d exp=3", level_out); end
        total++; if (interrupt_out !== 1'b0) begin bad++; $display("FAIL nest_ret1_io got=%0b exp=0", interrupt_out); end
        ret_in = 1'b1; cycle(); ret_in = 1'b0; #1;
        total++; if (interrupt_out !== 1'b1) begin bad++; $display("FAIL nest_v2_io got=%0b exp=1", interrupt_out); end
        total++; if (int_addr !== 32'h60) begin bad++; $display("FAIL nest_v2_addr got=%h exp=60", int_addr); end
        total++; if (level_out !== 3'd2) begin bad++; $display("FAIL nest_v2_lvl got=%0d exp=2", level_out); end
        cycle();
        ret_in = 1'b1; cycle(); ret_in = 1'b0; #1;
        total++; if (level_out !== 3'd0) begin bad++; $display("FAIL nest_end_lvl got=%0d exp=0", level_out); end
        total++; if (stack_err !== 1'b0) begin bad++; $display("FAIL nest_end_err got=%0b exp=0", stack_err); end
    endtask

    task automatic test_tie();
        csr_wr(Vec0, CsrRw, 32'h10, 5'd0);
        csr_wr(Vec5, CsrRw, 32'h50, 5'd0);
        csr_wr(Vec6, CsrRw, 32'h70, 5'd0);
        csr_wr(Cfg0, CsrRw, 32'h12, 5'd0);
        csr_wr(Cfg5, CsrRw, 32'h12, 5'd0);
        csr_wr(Cfg6, CsrRw, 32'h1A, 5'd0);
        ext_irq = 8'h21; cycle(); ext_irq = '0; #1;
        total++; if (int_addr !== 32'h10) begin bad++; $display("FAIL tie_addr got=%h exp=10", int_addr); end
        total++; if (level_out !== 3'd4) begin bad++; $display("FAIL tie_lvl got=%0d exp=4", level_out); end
        cycle();
        total++; if (interrupt_out !== 1'b0) begin bad++; $display("FAIL tie_equal_io got=%0b exp=0", interrupt_out); end
        ext_irq = 8'h40; cycle(); ext_irq = '0;
        ret_in = 1'b1; #1;
        total++; if (interrupt_out !== 1'b0) begin bad++; $display("FAIL ret_notake_io got=%0b exp=0", interrupt_out); end
        total++; if (level_out !== 3'd4) begin bad++; $display("FAIL ret_notake_lvl got=%0d exp=4", level_out); end
        cycle(); ret_in = 1'b0; #1;
        total++; if (int_addr !== 32'h70) begin bad++; $display("FAIL prio_win_addr got=%h exp=70", int_addr); end
        total++; if (level_out !== 3'd6) begin bad++; $display("FAIL prio_win_lvl got=%0d exp=6", level_out); end
        cycle();
        ret_in = 1'b1; cycle(); ret_in = 1'b0; #1;
        total++; if (interrupt_out !== 1'b1) begin bad++; $display("FAIL tie_v5_io got=%0b exp=1", interrupt_out); end
        total++; if (int_addr !== 32'h50) begin bad++; $display("FAIL tie_v5_addr got=%h exp=50", int_addr); end
        cycle();
        ret_in = 1'b1; cycle(); ret_in = 1'b0;
        rd(Cfg5, v);
        total++; if (v !== 32'h12) begin bad++; $display("FAIL tie_cfg5 got=%h exp=12", v); end
    endtask

    task automatic test_set_wins();
        ext_irq = 8'h02; cycle(); #1;
        total++; if (int_addr !== 32'h40) begin bad++; $display("FAIL setwin_addr got=%h exp=40", int_addr); end
        cycle(); ext_irq = '0;
        rd(Cfg1, v);
        total++; if (v !== 32'hF) begin bad++; $display("FAIL setwin_pend got=%h exp=f", v); end
        total++; if (level_out !== 3'd3) begin bad++; $display("FAIL setwin_lvl got=%0d exp=3", level_out); end
        ret_in = 1'b1; cycle(); ret_in = 1'b0; #1;
        total++; if (interrupt_out !== 1'b1) begin bad++; $display("FAIL setwin_retake got=%0b exp=1", interrupt_out); end
        total++; if (int_addr !== 32'h40) begin bad++; $display("FAIL setwin_readdr got=%h exp=40", int_addr); end
        cycle();
        ret_in = 1'b1; cycle(); ret_in = 1'b0;
    endtask

    task automatic test_stack_err();
        ret_in = 1'b1; cycle(); ret_in = 1'b0; #1;
        total++; if (stack_err !== 1'b1) begin bad++; $display("FAIL err_set got=%0b exp=1", stack_err); end
        total++; if (level_out !== 3'd0) begin bad++; $display("FAIL err_lvl got=%0d exp=0", level_out); end
        rd(Cfg1, v);
        total++; if (v !== 32'hE) begin bad++; $display("FAIL err_cfg1 got=%h exp=e", v); end
        csr_wr(Cfg0, CsrRs, 32'h0, 5'd0);
        rd(Cfg0, v);
        total++; if (v !== 32'h12) begin bad++; $display("FAIL rs_zero got=%h exp=12", v); end
        csr_wr(Cfg0, CsrRci, 32'h0, 5'd0);
        rd(Cfg0, v);
        total++; if (v !== 32'h12) begin bad++; $display("FAIL rci_zero got=%h exp=12", v); end
        csr_wr(Cfg0, CsrRc, 32'h2, 5'd0);
        rd(Cfg0, v);
        total++; if (v !== 32'h10) begin bad++; $display("FAIL rc_en got=%h exp=10", v); end
        csr_wr(Cfg0, CsrRsi, 32'h0, 5'd3);
        #1;
        total++; if (int_addr !== 32'h10) begin bad++; $display("FAIL rsi_take got=%h exp=10", int_addr); end
        cycle();
        ret_in = 1'b1; cycle(); ret_in = 1'b0; #1;
        total++; if (stack_err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%0b exp=1", stack_err); end
    endtask

    task automatic test_reset_mid();
        ext_irq = 8'h02; cycle(); ext_irq = '0;
        cycle();
        ext_irq = 8'h10; cycle(); ext_irq = '0; #1;
        total++; if (level_out !== 3'd5) begin bad++; $display("FAIL mid_depth2 got=%0d exp=5", level_out); end
        cycle();
        reset = 1'b0; #1;
        total++; if (level_out !== 3'd0) begin bad++; $display("FAIL mid_rst_lvl got=%0d exp=0", level_out); end
        total++; if (stack_err !== 1'b0) begin bad++; $display("FAIL mid_rst_err got=%0b exp=0", stack_err); end
        total++; if (interrupt_out !== 1'b0) begin bad++; $display("FAIL mid_rst_io got=%0b exp=0", interrupt_out); end
        rd(Cfg4, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL mid_rst_cfg4 got=%h exp=0", v); end
        cycle();
        reset = 1'b1; #1;
        total++; if (interrupt_out !== 1'b0) begin bad++; $display("FAIL mid_post_io got=%0b exp=0", interrupt_out); end
        ext_irq = 8'h02; cycle(); ext_irq = '0; #1;
        total++; if (interrupt_out !== 1'b0) begin bad++; $display("FAIL mid_disabled got=%0b exp=0", interrupt_out); end
        csr_wr(Vec1, CsrRw, 32'h44, 5'd0);
        csr_wr(Cfg1, CsrRw, 32'hF, 5'd0);
        #1;
        total++; if (int_addr !== 32'h44) begin bad++; $display("FAIL mid_reconf got=%h exp=44", int_addr); end
        cycle();
        ret_in = 1'b1; cycle(); cycle(); ret_in = 1'b0; #1;
        total++; if (stack_err !== 1'b1) begin bad++; $display("FAIL mid_stack_gone got=%0b exp=1", stack_err); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_nesting();
        test_tie();
        test_set_wins();
        test_stack_err();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/n_clic_vec.md
N_CLIC_VEC -- requirements
Module: n_clic_vec

Interface
REQ-001 Parameter VecLen, default 8, number of interrupt vectors.
REQ-002 Parameter PrioLevels, default 8, number of priority levels; PrioWidth = $clog2(PrioLevels).
REQ-003 Parameter CsrBase, default 12'hB00, base CSR address of the vector config block.
REQ-004 Parameter AddrWidth, default IMemAddrWidth, program-counter width.
REQ-005 clk  in  1  system clock, all state updates on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset; state is cleared while reset==0.
REQ-007 csr_enable  in  1  CSR instruction in current cycle.
REQ-008 csr_addr  in  12  CSR address.
REQ-009 csr_op  in  csr_op_t  RW/RS/RC/RWI/RSI/RCI.
REQ-010 rs1_zimm  in  5  immediate for the *I ops.
REQ-011 rs1_data  in  32  source data for the register ops.
REQ-012 pc_in  in  AddrWidth  next sequential/branch PC (return address).
REQ-013 ext_irq  in  VecLen  per-vector pending-set pulses.
REQ-014 ret_in  in  1  interrupt-return strobe from decode.
REQ-015 csr_out  out  32  read data of the addressed CSR (pre-write value).
REQ-016 int_addr  out  AddrWidth  handler address of the vector being taken.
REQ-017 pc_interrupt_sel  out  pc_interrupt_mux_t  selects pc_interrupt when a take occurs.
REQ-018 interrupt_out  out  1  one-cycle take strobe (drives RA save).
REQ-019 level_out  out  PrioWidth  effective level: target prio in a take cycle, else current level.
REQ-020 stack_err  out  1  sticky error flag: return at level 0.

Function
REQ-021 Config CSR CsrBase+i (i<VecLen) SHALL hold bit0 pending, bit1 enable, bits[PrioWidth+1:2] prio; other bits read 0.
REQ-022 Vector CSR CsrBase+VecLen+i SHALL hold handler address in bits[AddrWidth-1:0].
REQ-023 Unmapped addresses SHALL read 0 and ignore writes; csr_out is combinational.
REQ-024 RS/RC with zero operand SHALL not modify state; RW always writes.
REQ-025 Candidate = pending & enable & prio > current level; highest prio wins, ties go to lowest index.
REQ-026 Take (combinational, same cycle a candidate exists, ret_in==0): interrupt_out=1, pc_interrupt_sel=interrupt, int_addr=winner vector entry.
REQ-027 On take edge: push current level onto level stack (depth PrioLevels), current level := winner prio, winner pending := 0.
REQ-028 ret_in SHALL pop the stack into current level at the edge; no take in a ret_in cycle; arbitration re-evaluates next cycle.
REQ-029 ret_in at level 0 (stack empty) SHALL leave state unchanged and set stack_err.
REQ-030 ext_irq[i] SHALL set pending[i]; set wins over a same-cycle CSR clear or take-clear of the same vector.
REQ-031 Prio 0 vectors SHALL never be taken; nesting only with strictly higher prio, so the stack cannot overflow.
REQ-032 CSR write and take in the same cycle: CSR update applies; take uses pre-write values.

Reset
REQ-033 While reset==0: all config/vector CSRs 0, current level 0, stack empty, stack_err 0, interrupt_out 0, pc_interrupt_sel normal, level_out 0, csr_out 0 via cleared state.
REQ-034 Reset assertion mid-nesting SHALL discard the stack with no take on the first post-reset cycle.

Verification
REQ-035 Write vec1 entry=0x40, cfg1 = prio3|en|pend -> next cycle interrupt_out=1, int_addr=0x40, level_out=3; following cycle pending1=0, level 3.
REQ-036 At level 3, pend vec2 prio2 -> no take; pend vec4 prio5 -> take, level 5; ret_in -> level 3; ret_in -> level 0, then vec2 taken.
REQ-037 vec0 and vec5 both prio4 pending -> vec0 taken first, vec5 after ret.
REQ-038 ext_irq[1] pulsed in the same cycle vec1 is taken -> pending1 remains 1; re-taken after ret.
REQ-039 ret_in at level 0 -> stack_err=1, level 0, no other change; CSRRS cfg0 with rs1=x0 -> no change.
REQ-040 reset driven to 0 at nesting depth 2 -> all outputs 0, no take after release until re-configured.
